instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  IF stage of the RV64I 5-stage pipe; sole upstream producer of fetch_data_t for decode.
//  - Owns the PC; issues one instruction-bus request at a time.
//  - Holds each fetched word until decode accepts it.
//  - Handles execute-stage redirects, discarding any in-flight fetch.
// PARAMETERS
//  RESET_PC  64'h0000_0000_8000_0000  PC loaded on reset
// PORTS
//  clk             in   1    clock, all state on rising edge
//  reset           in   1    asynchronous, active-low reset
//  ireq_valid      out  1    instruction request valid
//  ireq_addr       out  64   request address (= PC of the fetch)
//  iresp_data_ok   in   1    response valid this cycle; completes the outstanding request
//  iresp_data      in   32   instruction word, valid with iresp_data_ok
//  redirect_valid  in   1    branch/jump taken in execute, 1-cycle pulse
//  redirect_pc     in   64   redirect target
//  out             out  fetch_data_t  {raw_instr, pc, valid} to decode
//  out_ready       in   1    decode accepts out this cycle
//  out_misalign    out  1    out.pc[1:0]!=0 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset==0): state=REQ, pc=RESET_PC, pend_pc=0, out=0, out_misalign=0.
//  - States:
//    - REQ: request outstanding.
//    - HOLD: word captured, presented to decode.
//    - DISCARD: stale request outstanding after redirect.
//  - ireq_valid=1 in REQ and DISCARD, else 0.
//  - ireq_addr=pc in REQ, old pc in DISCARD; stable while ireq_valid=1 until data_ok.
//  - out.valid=1 only in HOLD; out.pc/raw_instr registered, stable in HOLD.
//  - REQ:
//    - data_ok & !redirect -> HOLD; out={iresp_data, pc, 1}.
//    - data_ok & redirect -> REQ; pc=redirect_pc; data dropped.
//    - !data_ok & redirect -> DISCARD; pend_pc=redirect_pc.
//    - else stay.
//  - HOLD:
//    - redirect (priority over out_ready) -> REQ; pc=redirect_pc; held word dropped; out.valid=0 next cycle.
//    - out_ready -> REQ; pc=pc+4 (64-bit wrap, no carry-out).
//    - else stay; out unchanged.
//  - DISCARD:
//    - data_ok -> REQ; pc = redirect ? redirect_pc : pend_pc; data dropped.
//    - !data_ok & redirect -> stay; pend_pc=redirect_pc (last redirect wins).
//  - Latency: data_ok in cycle t -> out.valid in t+1; accept in t -> next request in t+1.
//    Peak throughput 1 instr / 2 cycles with 0-wait bus.
//  - Reset mid-request: state returns to REQ at RESET_PC. The bus must drop the prior request.
//  - A response with no request outstanding is ignored (only possible in HOLD).
// CONFIGURATION
//  - IF_MISALIGN_CHECK_EN defined:
//    - Entering REQ with pc[1:0]!=0: no bus request (ireq_valid=0).
//    - Next cycle -> HOLD with out={32'h0, pc, 1}, out_misalign=1.
//    - Redirect and accept rules as for HOLD.
//  - Undefined:
//    - out_misalign tied 0.
//    - Any pc is requested on the bus unmodified.
// TESTING
//  - Reset -> first ireq_addr=0x8000_0000. data_ok=1, data=0x00000013 -> next cycle out={0x13, 0x8000_0000, 1}.
//  - out_ready=1 every cycle, 0-wait bus -> pcs 0x8000_0000, 0x8000_0004, 0x8000_0008 on alternate cycles.
//  - out_ready=0 for 5 cycles in HOLD -> out stable, ireq_valid=0. Then ready=1 -> request 0x8000_0004.
//  - Redirect to 0x8000_0100 while REQ with data_ok delayed 3 cycles:
//    - ireq_addr stays old pc until data_ok.
//    - Stale word is never presented.
//    - Next request is 0x8000_0100.
//  - redirect and out_ready together in HOLD -> word not counted as accepted; next request = redirect_pc.
//  - With IF_MISALIGN_CHECK_EN: redirect to 0x8000_0102 -> no bus request;
//    out={0, 0x8000_0102, 1}, out_misalign=1.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - RV64I IF stage: PC owner, single-outstanding fetch, decode handoff (option: IF_MISALIGN_CHECK_EN)
package instr_fetch_pkg;
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;
endpackage

module instr_fetch_stage
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t out,
    input  logic        out_ready,
    output logic        out_misalign
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] pend_pc;
    logic        misaligned;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned   = (pc[1:0] != 2'b00);
    assign out_misalign = misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (state == S_REQ && misaligned && !redirect_valid) begin
            misalign_q <= 1'b1;
        end else if (state == S_HOLD && (redirect_valid || out_ready)) begin
            misalign_q <= 1'b0;
        end
    end
`else
    assign misaligned   = 1'b0;
    assign out_misalign = 1'b0;
`endif

    // In DISCARD the pc register still holds the stale request address; the target waits in pend_pc.
    assign ireq_valid = ((state == S_REQ) && !misaligned) || (state == S_DISCARD);
    assign ireq_addr  = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            pend_pc <= 64'h0;
            out     <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (misaligned) begin
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end else begin
                            state <= S_HOLD;
                            out   <= '{raw_instr: 32'h0, pc: pc, valid: 1'b1};
                        end
                    end else if (iresp_data_ok && !redirect_valid) begin
                        state <= S_HOLD;
                        out   <= '{raw_instr: iresp_data, pc: pc, valid: 1'b1};
                    end else if (iresp_data_ok) begin
                        pc <= redirect_pc;
                    end else if (redirect_valid) begin
                        state   <= S_DISCARD;
                        pend_pc <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        state     <= S_REQ;
                        pc        <= redirect_pc;
                        out.valid <= 1'b0;
                    end else if (out_ready) begin
                        state     <= S_REQ;
                        pc        <= pc + 64'd4;
                        out.valid <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (iresp_data_ok) begin
                        state <= S_REQ;
                        pc    <= redirect_valid ? redirect_pc : pend_pc;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    fetch_data_t out;
    logic        out_ready = 1'b0;
    logic        out_misalign;

    int total = 0;
    int bad = 0;

    instr_fetch_stage dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out(out), .out_ready(out_ready), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr, input logic [63:0] pc, input logic v);
        check({tag, ".valid"}, 64'(out.valid), 64'(v));
        if (v) begin
            check({tag, ".instr"}, 64'(out.raw_instr), 64'(instr));
            check({tag, ".pc"}, out.pc, pc);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_ireq_valid", 64'(ireq_valid), 64'd1);
        check("rst_ireq_addr", ireq_addr, 64'h8000_0000);
        check("rst_out_valid", 64'(out.valid), 64'd0);
        check("rst_misalign", 64'(out_misalign), 64'd0);
        reset = 1'b1;
        tick();
        check("req0_addr", ireq_addr, 64'h8000_0000);

        // first fetch, then hold 5 cycles with decode stalled
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
        tick();
        iresp_data_ok = 1'b0;
        check_out("first", 32'h13, 64'h8000_0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("stall", 32'h13, 64'h8000_0000, 1'b1);
            check("stall_ireq_valid", 64'(ireq_valid), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("acc_out_valid", 64'(out.valid), 64'd0);
        check("acc_ireq_valid", 64'(ireq_valid), 64'd1);
        check("acc_ireq_addr", ireq_addr, 64'h8000_0004);

        // back-to-back streaming with 0-wait bus
        iresp_data_ok = 1'b1; out_ready = 1'b1; iresp_data = 32'h0000_0093;
        tick();
        check_out("strm_a", 32'h93, 64'h8000_0004, 1'b1);
        tick();
        check("strm_req8", ireq_addr, 64'h8000_0008);
        check("strm_req8_v", 64'(ireq_valid), 64'd1);
        tick();
        check_out("strm_b", 32'h93, 64'h8000_0008, 1'b1);
        tick();
        check("strm_reqC", ireq_addr, 64'h8000_000C);
        iresp_data_ok = 1'b0; out_ready = 1'b0;

        // redirect while waiting; response arrives 3 cycles later and is dropped
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("disc_addr", ireq_addr, 64'h8000_000C);
            check("disc_valid", 64'(ireq_valid), 64'd1);
            check("disc_out_valid", 64'(out.valid), 64'd0);
            tick();
        end
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick();
        iresp_data_ok = 1'b0;
        check("disc_stale_dropped", 64'(out.valid), 64'd0);
        check("redir_addr", ireq_addr, 64'h8000_0100);

        // redirect and out_ready together in HOLD: redirect wins
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0011;
        tick();
        iresp_data_ok = 1'b0;
        check_out("hold_100", 32'h11, 64'h8000_0100, 1'b1);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        tick();
        out_ready = 1'b0; redirect_valid = 1'b0;
        check("rr_out_valid", 64'(out.valid), 64'd0);
        check("rr_addr", ireq_addr, 64'h8000_0200);

        // two redirects during DISCARD: last one wins
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        tick();
        redirect_pc = 64'h8000_0400;
        tick();
        check("lw_addr_old", ireq_addr, 64'h8000_0200);
        redirect_valid = 1'b0; iresp_data_ok = 1'b1;
        tick();
        iresp_data_ok = 1'b0;
        check("lw_addr", ireq_addr, 64'h8000_0400);
        check("lw_out_valid", 64'(out.valid), 64'd0);

        // DISCARD completing in the same cycle as a fresh redirect
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0500;
        tick();
        redirect_pc = 64'h8000_0600; iresp_data_ok = 1'b1;
        tick();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        check("dr_addr", ireq_addr, 64'h8000_0600);

        // REQ with data_ok and redirect together: data dropped
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0700; iresp_data_ok = 1'b1;
        tick();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        check("qr_out_valid", 64'(out.valid), 64'd0);
        check("qr_addr", ireq_addr, 64'h8000_0700);

        // response in HOLD is ignored
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0033;
        tick();
        iresp_data = 32'h0000_0044;
        tick();
        iresp_data_ok = 1'b0;
        check_out("hold_ignore", 32'h33, 64'h8000_0700, 1'b1);

        // 64-bit PC wrap
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_req", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0055;
        tick();
        iresp_data_ok = 1'b0;
        check_out("wrap_hold", 32'h55, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("wrap_addr", ireq_addr, 64'h0);

        // misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; iresp_data_ok = 1'b1;
        tick();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        check("mis_no_req", 64'(ireq_valid), 64'd0);
        tick();
        check_out("mis_hold", 32'h0, 64'h8000_0102, 1'b1);
        check("mis_flag", 64'(out_misalign), 64'd1);
`else
        check("mis_req_valid", 64'(ireq_valid), 64'd1);
        check("mis_req_addr", ireq_addr, 64'h8000_0102);
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0077;
        tick();
        iresp_data_ok = 1'b0;
        check_out("mis_hold", 32'h77, 64'h8000_0102, 1'b1);
        check("mis_flag", 64'(out_misalign), 64'd0);
`endif

        // asynchronous reset mid-transaction
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_addr", ireq_addr, 64'h8000_0000);
        check("arst_out_valid", 64'(out.valid), 64'd0);
        check("arst_ireq_valid", 64'(ireq_valid), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_addr", ireq_addr, 64'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
